mem_access_unit: RTL and testbench

Parametrised, handshaked load/store unit between the core's memory stage and a word-organised data RAM with byte enables.
- Accepts one request at a time (8-op load/store encoding).
- Adds a base offset to the address and drives word address, byte enables and lane-aligned write data.
- Waits a variable number of cycles for the memory acknowledge, with a timeout.
- Returns the correctly sign- or zero-extended load result.

---
 rtl/mem_access_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: handshaked load/store unit between the core memory stage
// and a word-organised data RAM with byte enables.
//   IDLE -> ACCESS (wait for mem_ack, optional timeout) -> RESP -> IDLE
// Optional build macro: MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses respond with err=1 and never
//               touch the RAM.
//   undefined : low address bits are forced to natural alignment and the
//               access proceeds normally.
module mem_access_unit #(
  parameter int          ADDR_W      = 12,
  parameter logic [31:0] BASE_OFFSET = 32'h0,
  parameter int          TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        mem_ctrl,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       wdata_in,
  output logic              resp_valid,
  output logic [31:0]       rdata_out,
  output logic              err,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_LBU = 3'b011,
    OP_LHU = 3'b100,
    OP_SB  = 3'b101,
    OP_SH  = 3'b110,
    OP_SW  = 3'b111
  } op_t;

  // Counter only needs to reach TIMEOUT; keep at least one bit when disabled.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

  state_t             state;
  op_t                op_q;
  logic [1:0]         off_q;
  logic [CNT_W-1:0]   cnt;

  // Request-side decode
  op_t                req_op;
  logic [ADDR_W-1:0]  eff_addr;
  logic [1:0]         req_off;
  logic [1:0]         off_al;
  logic               req_is_store;
  logic               req_is_half;
  logic               req_is_word;
  logic [3:0]         req_be;
  logic [31:0]        req_wdata;
  logic               trap;

  // Completion-side decode
  logic [7:0]         byte_v;
  logic [15:0]        half_v;
  logic [31:0]        load_data;
  logic [CNT_W-1:0]   cnt_inc;
  logic               timeout_hit;

  assign req_op       = op_t'(mem_ctrl);
  // Base offset is added at full width; the cast discards the carry-out so
  // the address wraps silently inside the RAM.
  assign eff_addr     = ADDR_W'(addr_in + BASE_OFFSET);
  assign req_off      = eff_addr[1:0];
  assign req_is_store = (req_op == OP_SB) || (req_op == OP_SH) || (req_op == OP_SW);
  assign req_is_half  = (req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH);
  assign req_is_word  = (req_op == OP_LW) || (req_op == OP_SW);

`ifdef MISALIGN_TRAP_EN
  assign trap = (req_is_half && req_off[0]) || (req_is_word && (req_off != 2'b00));
`else
  assign trap = 1'b0;
`endif

  // Natural alignment of the lane offset: halfwords ignore bit 0, words ignore both.
  always_comb begin
    off_al = req_off;
    if (req_is_half)      off_al = {req_off[1], 1'b0};
    else if (req_is_word) off_al = 2'b00;
  end

  // Byte enables and lane-replicated write data for the incoming request.
  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    req_be    = 4'b1111;
    req_wdata = 32'h0;
    unique case (req_op)
      OP_SB: begin
        req_be    = 4'b0001 << off_al;
        req_wdata = {4{wdata_in[7:0]}};
      end
      OP_SH: begin
        req_be    = 4'b0011 << {off_al[1], 1'b0};
        req_wdata = {2{wdata_in[15:0]}};
      end
      OP_SW: begin
        req_be    = 4'b1111;
        req_wdata = wdata_in;
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = 32'h0;
      end
    endcase
  end

  assign byte_v = mem_rdata[{off_q, 3'b000} +: 8];
  assign half_v = mem_rdata[{off_q[1], 4'b0000} +: 16];

  // Extend the selected byte/half of the RAM word according to the latched op.
  always_comb begin
    load_data = 32'h0;
    unique case (op_q)
      OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_data = {24'h0, byte_v};
      OP_LH:   load_data = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_data = {16'h0, half_v};
      OP_LW:   load_data = mem_rdata;
      default: load_data = 32'h0;
    endcase
  end

  assign cnt_inc     = cnt + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_LIMIT);

  // Control FSM with registered handshake and RAM-side outputs.
  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= OP_LB;
      off_q      <= 2'b00;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      rdata_out  <= 32'h0;
      err        <= 1'b0;
      mem_addr   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'b0000;
      mem_wdata  <= 32'h0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            op_q      <= req_op;
            off_q     <= off_al;
            cnt       <= '0;
            if (trap) begin
              // Misaligned: answer with an error without touching the RAM.
              state      <= S_RESP;
              resp_valid <= 1'b1;
              err        <= 1'b1;
              rdata_out  <= 32'h0;
            end else begin
              state     <= S_ACCESS;
              mem_en    <= 1'b1;
              mem_we    <= req_is_store;
              mem_addr  <= eff_addr[ADDR_W-1:2];
              mem_be    <= req_be;
              mem_wdata <= req_wdata;
            end
          end
        end

        S_ACCESS: begin
          if (mem_ack) begin
            // An ack in the same cycle the limit is reached still completes.
            state      <= S_RESP;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            cnt        <= '0;
            resp_valid <= 1'b1;
            err        <= 1'b0;
            rdata_out  <= load_data;
          end else if (timeout_hit) begin
            state      <= S_RESP;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            cnt        <= '0;
            resp_valid <= 1'b1;
            err        <= 1'b1;
            rdata_out  <= 32'h0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_RESP: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          err        <= 1'b0;
          rdata_out  <= 32'h0;
          req_ready  <= 1'b1;
        end

        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for mem_access_unit (TIMEOUT=4).
// Expected responses are queued as requests are issued; a negedge monitor
// pops and compares them whenever resp_valid is seen.
module tb_mem_access_unit;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        mem_ctrl;
  logic [31:0]       addr_in;
  logic [31:0]       wdata_in;
  logic              resp_valid;
  logic [31:0]       rdata_out;
  logic              err;
  logic [ADDR_W-3:0] mem_addr;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  int errors = 0;
  int checks = 0;
  logic [32:0] sb[$];   // {err, rdata}

  mem_access_unit #(
    .ADDR_W     (ADDR_W),
    .BASE_OFFSET(32'h0),
    .TIMEOUT    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .mem_ctrl  (mem_ctrl),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .resp_valid(resp_valid),
    .rdata_out (rdata_out),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: every resp_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", {31'h0, resp_valid}, 32'h0);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        check("resp_err", {31'h0, err}, {31'h0, e[32]});
        check("resp_rdata", rdata_out, e[31:0]);
      end
    end
  end

  // Present one request for exactly one accepting edge; returns #1 after that edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    check("issue_ready", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1;
    mem_ctrl  = op;
    addr_in   = addr;
    wdata_in  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Called at a negedge in ACCESS: ack now, expect the response pulse one cycle later, then IDLE.
  task automatic ack_and_resp(input logic [31:0] rd, input string tag);
    mem_rdata = rd;
    mem_ack   = 1'b1;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    @(negedge clk);
    check({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h1);
    check({tag, "_en_dropped"}, {31'h0, mem_en}, 32'h0);
    check({tag, "_busy_in_resp"}, {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    check({tag, "_resp_single"}, {31'h0, resp_valid}, 32'h0);
    check({tag, "_ready_back"}, {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en_cnt;
    logic seen;

    rst       = 1'b1;
    req_valid = 1'b0;
    mem_ctrl  = 3'b000;
    addr_in   = 32'h0;
    wdata_in  = 32'h0;
    mem_rdata = 32'h0;
    mem_ack   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_mem_en", {31'h0, mem_en}, 32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_rdata", rdata_out, 32'h0);
    check("rst_be", {28'h0, mem_be}, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    // LB at byte 3: sign-extended 0x80, earliest completion.
    sb.push_back({1'b0, 32'hFFFF_FF80});
    issue(3'b000, 32'h103, 32'h0);
    @(negedge clk);
    check("lb_en", {31'h0, mem_en}, 32'h1);
    check("lb_we", {31'h0, mem_we}, 32'h0);
    check("lb_addr", {22'h0, mem_addr}, 32'h40);
    check("lb_be", {28'h0, mem_be}, 32'hF);
    check("lb_ready_busy", {31'h0, req_ready}, 32'h0);
    ack_and_resp(32'h80FF_0000, "lb");

    // LHU then LH on the upper half.
    sb.push_back({1'b0, 32'h0000_BEEF});
    issue(3'b100, 32'h002, 32'h0);
    @(negedge clk);
    check("lhu_addr", {22'h0, mem_addr}, 32'h0);
    ack_and_resp(32'hBEEF_1234, "lhu");
    sb.push_back({1'b0, 32'hFFFF_BEEF});
    issue(3'b001, 32'h002, 32'h0);
    @(negedge clk);
    ack_and_resp(32'hBEEF_1234, "lh");

    // LBU at byte 1.
    sb.push_back({1'b0, 32'h0000_00F0});
    issue(3'b011, 32'h001, 32'h0);
    @(negedge clk);
    ack_and_resp(32'h0000_F000, "lbu");

    // SB with ack in the 4th ACCESS cycle: also the ack-wins-at-limit case.
    sb.push_back({1'b0, 32'h0});
    issue(3'b101, 32'h005, 32'h0000_00A5);
    en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_en === 1'b1) en_cnt++;
    end
    check("sb_we", {31'h0, mem_we}, 32'h1);
    check("sb_be", {28'h0, mem_be}, 32'h2);
    check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    check("sb_addr", {22'h0, mem_addr}, 32'h1);
    check("sb_en_cycles", en_cnt, 32'd4);
    ack_and_resp(32'h0, "sb");

    // SH with address wrap: 0x1006 truncates to byte 0x006.
    sb.push_back({1'b0, 32'h0});
    issue(3'b110, 32'h0000_1006, 32'h1234_BEEF);
    @(negedge clk);
    check("sh_addr_wrap", {22'h0, mem_addr}, 32'h1);
    check("sh_be", {28'h0, mem_be}, 32'hC);
    check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    check("sh_we", {31'h0, mem_we}, 32'h1);
    ack_and_resp(32'h0, "sh");

    // LW timeout: no ack at all.
    sb.push_back({1'b1, 32'h0});
    issue(3'b010, 32'h010, 32'h0);
    en_cnt = 0;
    seen   = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen = 1'b1;
      else if (mem_en === 1'b1) en_cnt++;
    end
    check("to_resp_seen", {31'h0, seen}, 32'h1);
    check("to_en_cycles", en_cnt, 32'd4);
    @(negedge clk);
    check("to_ready_back", {31'h0, req_ready}, 32'h1);

    // LW at misaligned byte 2.
`ifdef MISALIGN_TRAP_EN
    sb.push_back({1'b1, 32'h0});
    issue(3'b010, 32'h002, 32'h0);
    @(negedge clk);
    check("mis_en_low", {31'h0, mem_en}, 32'h0);
    check("mis_resp", {31'h0, resp_valid}, 32'h1);
    @(negedge clk);
    check("mis_ready_back", {31'h0, req_ready}, 32'h1);
`else
    sb.push_back({1'b0, 32'h1234_5678});
    issue(3'b010, 32'h002, 32'h0);
    @(negedge clk);
    check("mis_addr", {22'h0, mem_addr}, 32'h0);
    check("mis_be", {28'h0, mem_be}, 32'hF);
    ack_and_resp(32'h1234_5678, "mis");
`endif

    // Busy request ignored, then reset during ACCESS with a same-cycle ack.
    issue(3'b010, 32'h020, 32'h0);
    @(negedge clk);
    req_valid = 1'b1;
    mem_ctrl  = 3'b000;
    addr_in   = 32'h040;
    @(negedge clk);
    check("busy_addr_held", {22'h0, mem_addr}, 32'h8);
    check("busy_not_ready", {31'h0, req_ready}, 32'h0);
    check("busy_en", {31'h0, mem_en}, 32'h1);
    req_valid = 1'b0;
    rst       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    check("rstacc_en", {31'h0, mem_en}, 32'h0);
    check("rstacc_no_resp", {31'h0, resp_valid}, 32'h0);
    check("rstacc_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    check("rstacc_no_resp2", {31'h0, resp_valid}, 32'h0);

    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
